// File: rtl/dec_primo_pkg.sv
// Shared constants and the elaboration-time primality helper for dec_primo.
package dec_primo_pkg;

    localparam int unsigned MAX_WIDTH = 8;

    // Trial division over 2..n-1. Only called with constant arguments while
    // the ROM contents are being built, so it never becomes hardware.
    function automatic bit is_prime(input int unsigned n);
        bit result;
        result = (n >= 2);
        for (int unsigned d = 2; d < n; d++) begin
            if ((n % d) == 0) begin
                result = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/prime_rom.sv
// Constant lookup table: hit is 1 when addr is a prime number.
module prime_rom
    import dec_primo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] addr,
    output logic             hit
);

    localparam int unsigned DEPTH = 1 << WIDTH;

    logic [DEPTH-1:0] prime_tbl;

    // One constant bit per address, decided at elaboration.
    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        localparam bit IsPrime = is_prime(i);
        assign prime_tbl[i] = IsPrime;
    end

    // Single-level mux into the constant table; unknowns on addr pass through.
    assign hit = prime_tbl[addr];

endmodule

// File: rtl/dec_primo.sv
// Registered prime detector: led reflects the num sampled on the previous edge.
module dec_primo
    import dec_primo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] num,
    output logic             led
);

    // Reject widths the table is not meant to cover.
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("dec_primo: WIDTH must be in 2..8");
    end

    logic hit;

    prime_rom #(
        .WIDTH(WIDTH)
    ) u_rom (
        .addr(num),
        .hit (hit)
    );

    // Output flop with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= hit;
        end
    end

endmodule

// File: tb/tb_dec_primo.sv
// Self-checking bench for dec_primo at WIDTH=4 and WIDTH=8.
module tb_dec_primo;

    logic       clk;
    logic       rst;
    logic [3:0] num4;
    logic [7:0] num8;
    logic       led4;
    logic       led8;

    int n_pass;
    int n_total;

    typedef struct {
        string name;
        logic  exp;
        bit    w8;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic       r;
        logic [3:0] n;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    dec_primo #(
        .WIDTH(4)
    ) dut4 (
        .clk(clk),
        .rst(rst),
        .num(num4),
        .led(led4)
    );

    dec_primo #(
        .WIDTH(8)
    ) dut8 (
        .clk(clk),
        .rst(rst),
        .num(num8),
        .led(led8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Reference model: trial division up to sqrt(n).
    function automatic logic ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if ((n % d) == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_out();
        exp_t  x;
        logic  got;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: got empty queue, required an expected entry");
            return;
        end
        x   = sb.pop_front();
        got = x.w8 ? led8 : led4;
        if (got === x.exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: led=%b required %b", x.name, got, x.exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, check after the edge.
    task automatic apply(input logic r, input logic [7:0] n, input logic e,
                         input string nm, input bit w8);
        @(negedge clk);
        rst = r;
        if (w8) num8 = n;
        else    num4 = n[3:0];
        sb.push_back('{nm, e, w8});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        num4    = 4'd0;
        num8    = 8'd0;

        // Reset held 3 cycles with num=7, then release, then 1..15 sweep, then 0.
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 4'd7, 1'b0});
        vecs.push_back('{1'b0, 4'd7,  1'b1});
        vecs.push_back('{1'b0, 4'd1,  1'b0});
        vecs.push_back('{1'b0, 4'd2,  1'b1});
        vecs.push_back('{1'b0, 4'd3,  1'b1});
        vecs.push_back('{1'b0, 4'd4,  1'b0});
        vecs.push_back('{1'b0, 4'd5,  1'b1});
        vecs.push_back('{1'b0, 4'd6,  1'b0});
        vecs.push_back('{1'b0, 4'd7,  1'b1});
        vecs.push_back('{1'b0, 4'd8,  1'b0});
        vecs.push_back('{1'b0, 4'd9,  1'b0});
        vecs.push_back('{1'b0, 4'd10, 1'b0});
        vecs.push_back('{1'b0, 4'd11, 1'b1});
        vecs.push_back('{1'b0, 4'd12, 1'b0});
        vecs.push_back('{1'b0, 4'd13, 1'b1});
        vecs.push_back('{1'b0, 4'd14, 1'b0});
        vecs.push_back('{1'b0, 4'd15, 1'b0});
        vecs.push_back('{1'b0, 4'd0,  1'b0});
        vecs.push_back('{1'b0, 4'd2,  1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, {4'd0, vecs[i].n}, vecs[i].e,
                  $sformatf("w4_tbl[%0d] rst=%0b num=%0d", i, vecs[i].r, vecs[i].n), 1'b0);
        end

        // Mid-stream reset while num=11, then recovery on the next edge.
        apply(1'b0, 8'd9,  1'b0, "midrst_pre9",      1'b0);
        apply(1'b0, 8'd11, 1'b1, "midrst_pre11",     1'b0);
        apply(1'b1, 8'd11, 1'b0, "midrst_rst11",     1'b0);
        apply(1'b0, 8'd11, 1'b1, "midrst_resume11",  1'b0);
        apply(1'b0, 8'd12, 1'b0, "midrst_resume12",  1'b0);
        apply(1'b0, 8'd13, 1'b1, "midrst_resume13",  1'b0);

        // Glitch 4 -> 5 -> 4 between edges must not be captured.
        apply(1'b0, 8'd4, 1'b0, "glitch_pre4", 1'b0);
        @(negedge clk);
        num4 = 4'd5;
        #1 num4 = 4'd4;
        sb.push_back('{"glitch_4_5_4", 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check_out();
        // Mid-cycle change must not move led before the next edge.
        apply(1'b0, 8'd5, 1'b1, "glitch_pre5", 1'b0);
        @(negedge clk);
        num4 = 4'd4;
        sb.push_back('{"hold_between_edges", 1'b1, 1'b0});
        #2;
        check_out();
        @(posedge clk);
        #1;

        // WIDTH=8 exhaustive against the reference model.
        for (int n = 0; n < 256; n++) begin
            apply(1'b0, 8'(n), ref_prime(n), $sformatf("w8_num=%0d", n), 1'b1);
        end

        // WIDTH=8 spot values.
        apply(1'b0, 8'd251, 1'b1, "w8_spot251", 1'b1);
        apply(1'b0, 8'd255, 1'b0, "w8_spot255", 1'b1);
        apply(1'b0, 8'd127, 1'b1, "w8_spot127", 1'b1);
        apply(1'b0, 8'd221, 1'b0, "w8_spot221", 1'b1);
        apply(1'b1, 8'd251, 1'b0, "w8_reset",   1'b1);
        apply(1'b0, 8'd2,   1'b1, "w8_spot2",   1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
